// File: rtl/string_receiver_pkg.sv
// Shared types and defaults for the line-oriented string receiver.
// Terminator values and buffer depth default live here so every file agrees.
package string_receiver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  localparam logic [7:0] DEF_TERM_CR = 8'h0D;
  localparam logic [7:0] DEF_TERM_LF = 8'h0A;
  localparam int         DEF_MAX_LEN = 16;

  // Address width for a buffer of n entries (at least one bit).
  function automatic int addr_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/string_receiver_if.sv
// Byte-in / line-out bus of the string receiver; master = UART + consumer side,
// slave = the receiver itself.
interface string_receiver_if
  import string_receiver_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN
);
  localparam int AW = addr_w(MAX_LEN);
  localparam int LW = $clog2(MAX_LEN + 1);

  logic [7:0]    i_rx_data;
  logic          i_rx_end;
  logic [AW-1:0] i_rd_addr;
  logic          i_line_ack;
  logic [7:0]    o_rd_data;
  logic [LW-1:0] o_line_len;
  logic          o_line_valid;
  logic          o_overflow;
  logic          o_busy;

  modport master (
    output i_rx_data, i_rx_end, i_rd_addr, i_line_ack,
    input  o_rd_data, o_line_len, o_line_valid, o_overflow, o_busy
  );

  modport slave (
    input  i_rx_data, i_rx_end, i_rd_addr, i_line_ack,
    output o_rd_data, o_line_len, o_line_valid, o_overflow, o_busy
  );

endinterface

// File: rtl/string_receiver_line_buffer_ram.sv
// MAX_LEN x 8 simple dual-port line store: synchronous write, registered read.
// No reset on purpose; the controller masks read data until it is meaningful.
module line_buffer_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/string_receiver.sv
// Collects UART bytes into a line buffer until CR/LF, then holds the line
// (length, overflow flag, random-access read port) until the consumer acks.
module string_receiver
  import string_receiver_pkg::*;
#(
  parameter int         MAX_LEN = DEF_MAX_LEN,
  parameter logic [7:0] TERM_CR = DEF_TERM_CR,
  parameter logic [7:0] TERM_LF = DEF_TERM_LF
) (
  input logic              i_Clk,
  input logic              i_Rst_n,
  string_receiver_if.slave bus
);

  localparam int            AW   = addr_w(MAX_LEN);
  localparam int            LW   = $clog2(MAX_LEN + 1);
  localparam logic [LW-1:0] FULL = LW'(MAX_LEN);

  state_t        state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] len_q, len_d;
  logic          ovf_q, ovf_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          rd_ok_q, rd_ok_d;

  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    ram_rdata;
  logic          is_term;
  logic          ack_done;

  assign is_term  = (bus.i_rx_data == TERM_CR) || (bus.i_rx_data == TERM_LF);
  assign ack_done = (state_q == ST_DONE) && bus.i_line_ack;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    we      = 1'b0;
    waddr   = '0;

    // An acked DONE behaves as IDLE for any byte arriving in the same cycle.
    if (ack_done) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end

    if (bus.i_rx_end) begin
      if (state_q == ST_IDLE || ack_done) begin
        if (!is_term) begin
          we      = 1'b1;
          waddr   = '0;
          cnt_d   = LW'(1);
          state_d = ST_COLLECT;
        end
      end else if (state_q == ST_COLLECT) begin
        if (is_term) begin
          len_d   = cnt_q;
          state_d = ST_DONE;
        end else if (cnt_q < FULL) begin
          we    = 1'b1;
          waddr = cnt_q[AW-1:0];
          cnt_d = cnt_q + LW'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end else begin
        // DONE without ack: buffer is frozen, byte is lost.
        ovf_d = 1'b1;
      end
    end

    valid_d = (state_d == ST_DONE);
    busy_d  = (state_d == ST_COLLECT);
    // Mask decision travels with the address so it lines up with the RAM's registered read.
    rd_ok_d = !((state_q == ST_DONE) && (LW'(bus.i_rd_addr) >= len_q));
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      rd_ok_q <= rd_ok_d;
    end
  end

  line_buffer_ram #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_ram (
    .clk   (i_Clk),
    .we    (we),
    .waddr (waddr),
    .wdata (bus.i_rx_data),
    .raddr (bus.i_rd_addr),
    .rdata (ram_rdata)
  );

  assign bus.o_rd_data    = rd_ok_q ? ram_rdata : 8'h00;
  assign bus.o_line_len   = len_q;
  assign bus.o_line_valid = valid_q;
  assign bus.o_overflow   = ovf_q;
  assign bus.o_busy       = busy_q;

endmodule

// File: tb/tb_string_receiver.sv
// Scoreboard bench for string_receiver: stimulus queues expectations, a
// negedge monitor compares them and checks every completed line as it appears.
module tb_string_receiver;

  localparam int ML      = 16;
  localparam int S_VALID = 0;
  localparam int S_LEN   = 1;
  localparam int S_OVF   = 2;
  localparam int S_BUSY  = 3;
  localparam int S_RD    = 4;

  typedef struct {
    string name;
    int    sig;
    int    exp;
  } chk_t;

  typedef struct {
    int len;
    int ovf;
  } line_t;

  logic i_Clk   = 1'b0;
  logic i_Rst_n = 1'b0;

  string_receiver_if #(.MAX_LEN(ML)) bus ();

  string_receiver #(.MAX_LEN(ML)) dut (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .bus     (bus)
  );

  always #5 i_Clk = ~i_Clk;

  chk_t  sb[$];
  line_t lines[$];
  int    n_chk = 0;
  int    n_pass = 0;
  logic  prev_valid = 1'b0;

  function automatic int peek(int s);
    case (s)
      S_VALID: return int'(bus.o_line_valid);
      S_LEN:   return int'(bus.o_line_len);
      S_OVF:   return int'(bus.o_overflow);
      S_BUSY:  return int'(bus.o_busy);
      default: return int'(bus.o_rd_data);
    endcase
  endfunction

  task automatic compare(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Monitor: every completed line must match the next expected line.
  always @(negedge i_Clk) begin
    line_t l;
    chk_t  c;
    if (bus.o_line_valid && !prev_valid) begin
      if (lines.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_line: got line len %0d, want no line", bus.o_line_len);
      end else begin
        l = lines.pop_front();
        compare("line_len", int'(bus.o_line_len), l.len);
        compare("line_ovf", int'(bus.o_overflow), l.ovf);
      end
    end
    prev_valid = bus.o_line_valid;
    while (sb.size() > 0) begin
      c = sb.pop_front();
      compare(c.name, peek(c.sig), c.exp);
    end
  end

  task automatic chk(string name, int sig, int exp);
    chk_t c;
    c.name = name;
    c.sig  = sig;
    c.exp  = exp;
    sb.push_back(c);
  endtask

  task automatic expect_line(int len, int ovf);
    line_t l;
    l.len = len;
    l.ovf = ovf;
    lines.push_back(l);
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && sb.size() != 0; i++) @(negedge i_Clk);
    #1;
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL drain: got %0d pending checks, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic strobe(logic [7:0] b);
    bus.i_rx_data = b;
    bus.i_rx_end  = 1'b1;
    @(posedge i_Clk);
    #1;
    bus.i_rx_end  = 1'b0;
  endtask

  task automatic rd(int a, int exp, string name);
    bus.i_rd_addr = 4'(a);
    @(posedge i_Clk);
    #1;
    chk(name, S_RD, exp);
    drain();
  endtask

  task automatic ack();
    bus.i_line_ack = 1'b1;
    @(posedge i_Clk);
    #1;
    bus.i_line_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    bus.i_rx_data  = 8'h00;
    bus.i_rx_end   = 1'b0;
    bus.i_rd_addr  = '0;
    bus.i_line_ack = 1'b0;

    #2;
    chk("rst_valid", S_VALID, 0);
    chk("rst_len",   S_LEN,   0);
    chk("rst_ovf",   S_OVF,   0);
    chk("rst_busy",  S_BUSY,  0);
    chk("rst_rd",    S_RD,    0);
    drain();
    i_Rst_n = 1'b1;

    // "HI\r"
    expect_line(2, 0);
    strobe(8'h48);
    chk("hi_busy", S_BUSY, 1);
    strobe(8'h49);
    chk("hi_valid_pre", S_VALID, 0);
    strobe(8'h0D);
    chk("hi_valid", S_VALID, 1);
    chk("hi_len",   S_LEN,   2);
    chk("hi_ovf",   S_OVF,   0);
    chk("hi_busy_done", S_BUSY, 0);
    drain();
    rd(0,  8'h48, "hi_rd0");
    rd(1,  8'h49, "hi_rd1");
    rd(2,  8'h00, "hi_rd2");
    rd(15, 8'h00, "hi_rd15");
    ack();
    chk("hi_ack_valid", S_VALID, 0);
    drain();

    // "\r\n\r" from IDLE makes no line
    strobe(8'h0D);
    chk("empty_busy0", S_BUSY, 0);
    strobe(8'h0A);
    strobe(8'h0D);
    chk("empty_busy", S_BUSY,  0);
    chk("empty_valid", S_VALID, 0);
    drain();

    // 20 x 'A' into a 16-entry buffer
    expect_line(16, 1);
    for (int i = 0; i < 20; i++) begin
      strobe(8'h41);
      if (i == 15) chk("full_ovf0", S_OVF, 0);
      if (i == 16) chk("full_ovf1", S_OVF, 1);
      if (i == 19) chk("full_busy", S_BUSY, 1);
    end
    strobe(8'h0D);
    chk("full_len", S_LEN, 16);
    chk("full_ovf", S_OVF, 1);
    drain();
    for (int i = 0; i < 16; i++) rd(i, 8'h41, $sformatf("full_rd%0d", i));
    ack();
    chk("full_ack_ovf", S_OVF, 0);
    drain();

    // Byte in DONE without ack, then ack with same-cycle byte
    expect_line(1, 0);
    strobe(8'h51);
    strobe(8'h0D);
    drain();
    strobe(8'h5A);
    chk("done_drop_ovf",   S_OVF,   1);
    chk("done_drop_valid", S_VALID, 1);
    chk("done_drop_len",   S_LEN,   1);
    drain();
    rd(0, 8'h51, "done_rd0");
    rd(1, 8'h00, "done_rd1");
    bus.i_line_ack = 1'b1;
    strobe(8'h42);
    bus.i_line_ack = 1'b0;
    chk("ackbyte_busy",  S_BUSY,  1);
    chk("ackbyte_valid", S_VALID, 0);
    chk("ackbyte_ovf",   S_OVF,   0);
    drain();
    rd(0, 8'h42, "ackbyte_rd0");
    // Ack while collecting is ignored
    expect_line(2, 0);
    bus.i_line_ack = 1'b1;
    strobe(8'h43);
    bus.i_line_ack = 1'b0;
    chk("collect_ack_busy", S_BUSY, 1);
    strobe(8'h0D);
    chk("collect_ack_len", S_LEN, 2);
    drain();
    rd(1, 8'h43, "collect_ack_rd1");
    ack();
    drain();

    // Reset mid-line
    strobe(8'h41);
    strobe(8'h42);
    chk("mid_busy", S_BUSY, 1);
    drain();
    i_Rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", S_VALID, 0);
    chk("mid_rst_len",   S_LEN,   0);
    chk("mid_rst_ovf",   S_OVF,   0);
    chk("mid_rst_busy",  S_BUSY,  0);
    chk("mid_rst_rd",    S_RD,    0);
    drain();
    i_Rst_n = 1'b1;
    expect_line(1, 0);
    strobe(8'h43);
    strobe(8'h0D);
    chk("post_rst_len", S_LEN, 1);
    drain();
    rd(0, 8'h43, "post_rst_rd0");
    ack();

    // Back-to-back "XY\n"
    expect_line(2, 0);
    strobe(8'h58);
    strobe(8'h59);
    strobe(8'h0A);
    chk("b2b_valid", S_VALID, 1);
    chk("b2b_len",   S_LEN,   2);
    drain();
    rd(0, 8'h58, "b2b_rd0");
    rd(1, 8'h59, "b2b_rd1");
    rd(2, 8'h00, "b2b_rd2");
    ack();
    drain();
    @(negedge i_Clk);
    #1;

    n_chk++;
    if (lines.size() == 0) n_pass++;
    else $display("FAIL lines_seen: got %0d lines missing, want 0", lines.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
